fetch_stage: RTL
================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 clk  in  1  clock; all state updates on rising edge.
REQ-002 resetn  in  1  reset, synchronous, active-low; clock clk.
REQ-003 inst_req  out  1  instruction bus request valid.
REQ-004 inst_addr  out  32  request address (current fetch PC).
REQ-005 inst_addr_ok  in  1  request accepted this cycle when high together with inst_req.
REQ-006 inst_data_ok  in  1  read data returned this cycle.
REQ-007 inst_rdata  in  32  returned instruction word.
REQ-008 branch  in  1  single-cycle redirect pulse from decode.
REQ-009 branch_pc  in  32  redirect target, sampled when branch=1.
REQ-010 branch_ack  out  1  fetch can accept a branch this cycle (delay slot already in flight or held).
REQ-011 exc_redirect  in  1  exception/eret redirect pulse; highest priority.
REQ-012 exc_pc  in  32  exception redirect target.
REQ-013 ready_i  in  1  downstream consumes valid_o/pc_o/inst_o at this edge.
REQ-014 valid_o, pc_o[31:0], inst_o[31:0]  out  registered fetched instruction packet.
REQ-015 exc_o  out  1, exccode_o  out  5  fetch exception flag/code for the packet.

Function
REQ-016 States SHALL be S_REQ, S_WAIT, S_OUT, S_DROP; at most one bus transaction outstanding.
REQ-017 S_REQ: inst_req=1 only if pc[1:0]==0; inst_req&&inst_addr_ok -> S_WAIT.
REQ-018 S_REQ with pc[1:0]!=0: no request; next edge loads packet with exc_o=1, exccode_o=5'h04 (AdEL), inst_o=0, valid_o=1 -> S_OUT.
REQ-019 S_WAIT: inst_data_ok -> load pc_o=pc, inst_o=inst_rdata, exc_o=0, exccode_o=0, valid_o=1 -> S_OUT; latency data_ok to valid_o = 1 cycle.
REQ-020 S_OUT: outputs held stable while ready_i=0; ready_i=1 -> valid_o=0, pc=pending redirect target if set else pc+4, clear pending, -> S_REQ.
REQ-021 branch_ack SHALL be 1 exactly in S_WAIT and S_OUT; branch with branch_ack=1 records pending redirect = branch_pc, applied after the current (delay-slot) packet is consumed.
REQ-022 branch while branch_ack=0 SHALL be ignored.
REQ-023 exc_redirect SHALL: clear pending branch redirect; set pc=exc_pc; drop valid_o at next edge; from S_OUT or S_REQ without same-cycle addr_ok -> S_REQ; from S_WAIT, or S_REQ with same-cycle addr_ok -> S_DROP.
REQ-024 S_DROP: inst_req=0; inst_data_ok discarded (no packet) -> S_REQ; further exc_redirect updates pc only.
REQ-025 exc_redirect and branch in same cycle: exc wins, branch ignored.
REQ-026 pc+4 SHALL wrap modulo 2^32; inst_addr SHALL change in S_REQ only via exc_redirect or reset.

Reset
REQ-027 resetn=0 at edge: pc=32'hBFC00000, state=S_REQ, pending cleared, valid_o=0, pc_o=0, inst_o=0, exc_o=0, exccode_o=0.
REQ-028 Reset mid-transaction SHALL abandon it; bus is assumed reset together with this block.

Verification
REQ-029 Release reset, addr_ok next cycle, data_ok 2 cycles later with 32'h24080001, ready_i=1 -> inst_addr=BFC00000, then valid_o=1 pc_o=BFC00000 inst_o=24080001, next request BFC00004.
REQ-030 Packet BFC00000 consumed, branch=1 branch_pc=BFC00100 while BFC00004 in S_WAIT -> branch_ack=1, BFC00004 delivered, next inst_addr=BFC00100.
REQ-031 ready_i=0 for 3 cycles in S_OUT -> valid_o, pc_o, inst_o unchanged, inst_req=0, then consumed on 4th cycle.
REQ-032 exc_redirect exc_pc=BFC00380 in S_WAIT, data_ok next cycle -> no valid_o for that data, next inst_addr=BFC00380.
REQ-033 exc_redirect to 32'hBFC00382 -> no inst_req, valid_o=1 exc_o=1 exccode_o=04 pc_o=BFC00382.
REQ-034 Same-cycle branch (BFC00100) and exc_redirect (BFC00380) in S_OUT -> next inst_addr=BFC00380, BFC00100 never requested.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding bus read, registered output packet,
// delayed branch redirect (applied after the delay slot) and exception redirect.
module fetch_stage (
    input  logic        clk,
    input  logic        resetn,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        branch,
    input  logic [31:0] branch_pc,
    output logic        branch_ack,
    input  logic        exc_redirect,
    input  logic [31:0] exc_pc,
    input  logic        ready_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        exc_o,
    output logic [4:0]  exccode_o,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request is accepted on an edge where inst_req && inst_addr_ok;
    // data returns on an edge where inst_data_ok; the packet moves downstream on an
    // edge where valid_o && ready_i. branch is honoured only when branch_ack is high.

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_OUT  = 2'd2,
        S_DROP = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC   = 32'hBFC0_0000;
    localparam logic [4:0]  EXC_ADEL   = 5'h04;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] pc_o_q, pc_o_d;
    logic [31:0] inst_q, inst_d;
    logic        exc_q, exc_d;
    logic [4:0]  exccode_q, exccode_d;
    logic        aligned;

    assign aligned = (pc_q[1:0] == 2'b00);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_pc_d  = pend_pc_q;
        valid_d    = valid_q;
        pc_o_d     = pc_o_q;
        inst_d     = inst_q;
        exc_d      = exc_q;
        exccode_d  = exccode_q;
        inst_req   = 1'b0;
        branch_ack = 1'b0;

        case (state_q)
            S_REQ: begin
                inst_req = aligned;
                if (exc_redirect) begin
                    pc_d    = exc_pc;
                    pend_d  = 1'b0;
                    valid_d = 1'b0;
                    // An accepted request still owes us a data beat to swallow.
                    state_d = (aligned && inst_addr_ok) ? S_DROP : S_REQ;
                end else if (!aligned) begin
                    valid_d   = 1'b1;
                    pc_o_d    = pc_q;
                    inst_d    = 32'h0;
                    exc_d     = 1'b1;
                    exccode_d = EXC_ADEL;
                    state_d   = S_OUT;
                end else if (inst_addr_ok) begin
                    state_d = S_WAIT;
                end
            end

            S_WAIT: begin
                branch_ack = 1'b1;
                if (exc_redirect) begin
                    pc_d    = exc_pc;
                    pend_d  = 1'b0;
                    valid_d = 1'b0;
                    // Data arriving in the same cycle closes the transaction already.
                    state_d = inst_data_ok ? S_REQ : S_DROP;
                end else begin
                    if (branch) begin
                        pend_d    = 1'b1;
                        pend_pc_d = branch_pc;
                    end
                    if (inst_data_ok) begin
                        valid_d   = 1'b1;
                        pc_o_d    = pc_q;
                        inst_d    = inst_rdata;
                        exc_d     = 1'b0;
                        exccode_d = 5'h00;
                        state_d   = S_OUT;
                    end
                end
            end

            S_OUT: begin
                branch_ack = 1'b1;
                if (exc_redirect) begin
                    pc_d    = exc_pc;
                    pend_d  = 1'b0;
                    valid_d = 1'b0;
                    state_d = S_REQ;
                end else if (ready_i) begin
                    valid_d = 1'b0;
                    pend_d  = 1'b0;
                    state_d = S_REQ;
                    if (branch) begin
                        pc_d = branch_pc;
                    end else if (pend_q) begin
                        pc_d = pend_pc_q;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end else if (branch) begin
                    pend_d    = 1'b1;
                    pend_pc_d = branch_pc;
                end
            end

            S_DROP: begin
                if (exc_redirect) begin
                    pc_d   = exc_pc;
                    pend_d = 1'b0;
                end
                if (inst_data_ok) begin
                    state_d = S_REQ;
                end
            end

            default: begin
                state_d = S_REQ;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= S_REQ;
            pc_q      <= RESET_PC;
            pend_q    <= 1'b0;
            pend_pc_q <= 32'h0;
            valid_q   <= 1'b0;
            pc_o_q    <= 32'h0;
            inst_q    <= 32'h0;
            exc_q     <= 1'b0;
            exccode_q <= 5'h00;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_q    <= pend_d;
            pend_pc_q <= pend_pc_d;
            valid_q   <= valid_d;
            pc_o_q    <= pc_o_d;
            inst_q    <= inst_d;
            exc_q     <= exc_d;
            exccode_q <= exccode_d;
        end
    end

    assign inst_addr = pc_q;
    assign valid_o   = valid_q;
    assign pc_o      = pc_o_q;
    assign inst_o    = inst_q;
    assign exc_o     = exc_q;
    assign exccode_o = exccode_q;
    assign dbg_state = state_q;

endmodule
